// File: rtl/dp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_ctrl_pkg
// Purpose  : Shared definitions for the datapath arbiter: control-word field
//            layout, FSM state encoding and a control-word packing helper.
// Revision : 1.0 - initial release
// ============================================================================
package dp_ctrl_pkg;

  // Control-word layout: [15:13] ALU op, [12:9] mux A, [8:5] mux B,
  // [4:1] destination register, [0] write enable.
  localparam int c_cw_w    = 16;
  localparam int c_alu_w   = 3;
  localparam int c_sel_w   = 4;
  localparam int c_alu_lsb = 13;
  localparam int c_a_lsb   = 9;
  localparam int c_b_lsb   = 5;
  localparam int c_dst_lsb = 1;
  localparam int c_wr_bit  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [c_cw_w-1:0] pack_ctrl(
    input logic [c_alu_w-1:0] op,
    input logic [c_sel_w-1:0] a,
    input logic [c_sel_w-1:0] b,
    input logic [c_sel_w-1:0] dst,
    input logic               wr
  );
    logic [c_cw_w-1:0] w_word;
    w_word                          = '0;
    w_word[c_alu_lsb +: c_alu_w]    = op;
    w_word[c_a_lsb   +: c_sel_w]    = a;
    w_word[c_b_lsb   +: c_sel_w]    = b;
    w_word[c_dst_lsb +: c_sel_w]    = dst;
    w_word[c_wr_bit]                = wr;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker with sticky-owner override.
//            Scans from i_ptr upward (modulo N_REQ); a held lock lets the
//            current owner win outright while it keeps requesting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_lock,
  input  logic [IDX_W-1:0] i_owner,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Pick the locked owner if still requesting, else first request from i_ptr.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    if (i_lock && i_req[i_owner]) begin
      o_any = 1'b1;
      o_idx = i_owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        j = int'(i_ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        if (!o_any && i_req[j]) begin
          o_any = 1'b1;
          o_idx = IDX_W'(j);
        end
      end
    end
    o_grant[o_idx] = o_any;
  end

endmodule
`default_nettype wire

// File: rtl/dp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_arbiter
// Purpose  : Shares one ALU/mux/register-file datapath between N_REQ
//            requesters. Each accepted micro-op runs SETUP (operands settle,
//            no write), WRITE (write strobe) and RESP (completion + flag).
// Revision : 1.0 - initial release
// ============================================================================
module dp_arbiter
  import dp_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ALU_W = 3,
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [N_REQ*ALU_W-1:0] req_op,
  input  logic [N_REQ*SEL_W-1:0] req_a,
  input  logic [N_REQ*SEL_W-1:0] req_b,
  input  logic [N_REQ*SEL_W-1:0] req_dst,
  input  logic [N_REQ-1:0]       req_wr,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic                   rsp_flag,
  output logic                   busy,
  input  logic                   mayor,
  output logic [15:0]            o_signal
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_lock;
  logic               r_flag;
  logic [ALU_W-1:0]   r_op;
  logic [SEL_W-1:0]   r_a;
  logic [SEL_W-1:0]   r_b;
  logic [SEL_W-1:0]   r_dst;
  logic               r_wr;
  logic [15:0]        r_signal;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic               r_rsp_flag;
  logic               r_busy;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [ALU_W-1:0]   w_op;
  logic [SEL_W-1:0]   w_a;
  logic [SEL_W-1:0]   w_b;
  logic [SEL_W-1:0]   w_dst;
  logic               w_wr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_lock  (r_lock),
    .i_owner (r_owner),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Select the winning requester's micro-op fields.
  always_comb begin
    w_op  = '0;
    w_a   = '0;
    w_b   = '0;
    w_dst = '0;
    w_wr  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_op  = req_op [i*ALU_W +: ALU_W];
        w_a   = req_a  [i*SEL_W +: SEL_W];
        w_b   = req_b  [i*SEL_W +: SEL_W];
        w_dst = req_dst[i*SEL_W +: SEL_W];
        w_wr  = req_wr [i];
      end
    end
  end

  // Only combinational output: accept strobe, IDLE only, held low in reset.
  assign req_ready = (r_state == ST_IDLE && !rst) ? w_grant : '0;

  assign o_signal  = r_signal;
  assign rsp_valid = r_rsp_valid;
  assign rsp_flag  = r_rsp_flag;
  assign busy      = r_busy;

  // Sequencer: accept, settle operands, write, respond; outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_lock      <= 1'b0;
      r_flag      <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_dst       <= '0;
      r_wr        <= 1'b0;
      r_signal    <= '0;
      r_rsp_valid <= '0;
      r_rsp_flag  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          // Lock lapses as soon as the owner is seen idle-without-request.
          if (!req_valid[r_owner]) r_lock <= 1'b0;
          if (w_any) begin
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_dst    <= w_dst;
            r_wr     <= w_wr;
            r_owner  <= w_idx;
            r_rr_ptr <= (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_signal <= pack_ctrl(w_op, w_a, w_b, w_dst, 1'b0);
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_flag   <= mayor;
          r_signal <= pack_ctrl(r_op, r_a, r_b, r_dst, r_wr);
          r_state  <= ST_WRITE;
        end
        ST_WRITE: begin
          r_signal    <= '0;
          r_rsp_valid <= N_REQ'(1) << r_owner;
          r_rsp_flag  <= r_flag;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_lock  <= req_lock[r_owner];
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dp_arbiter.md
Name: dp_arbiter

Overview:
- Shares the single ALU / mux / register-file datapath between N_REQ independent requesters, e.g. several sequencing FSMs or a host port.
- Each requester submits one micro-operation: ALU op, mux-A select, mux-B select, destination register and write flag.
- The arbiter grants round-robin and drives the 16-bit datapath control word through a settle cycle and a write cycle.
- It returns the datapath comparison flag ("mayor") to the owner.
- Sits between the requesters and the datapath, in place of a hard-wired control FSM.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ALU_W, 3, ALU op field width.
- SEL_W, 4, width of each select field (mux A, mux B, destination register).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_lock  in  N_REQ  requester wants to keep ownership for its next request.
- req_op  in  N_REQ*ALU_W  ALU op per requester, packed with requester i at [i*ALU_W +: ALU_W].
- req_a  in  N_REQ*SEL_W  mux-A select per requester, packed.
- req_b  in  N_REQ*SEL_W  mux-B select per requester, packed.
- req_dst  in  N_REQ*SEL_W  destination register per requester, packed.
- req_wr  in  N_REQ  write enable per requester.
- req_ready  out  N_REQ  accept strobe, one-hot.
- rsp_valid  out  N_REQ  completion strobe, one-hot.
- rsp_flag  out  1  sampled comparison result.
- busy  out  1  operation in flight (state != IDLE).
- mayor  in  1  comparison flag from datapath.
- o_signal  out  16  datapath control word: [15:13] ALU op, [12:9] mux-A select, [8:5] mux-B select, [4:1] destination register, [0] write.

Behaviour:
- Reset (async):
  - State IDLE, rr_ptr=0, owner=0, lock_q=0, flag_q=0.
  - Outputs o_signal=0, req_ready=0, rsp_valid=0, rsp_flag=0, busy=0.
- FSM states are IDLE, SETUP, WRITE, RESP; one cycle each except IDLE.
- IDLE:
  - o_signal=0.
  - If lock_q=1 and req_valid[owner]=1, the winner is owner.
  - Otherwise the winner is the first set req_valid scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - If any winner exists: req_ready[winner]=1 (combinational, same cycle); latch op/a/b/dst/wr of the winner into cmd registers; owner<=winner; rr_ptr<=(winner+1) mod N_REQ; next state SETUP.
  - If no winner: lock_q<=0 and stay in IDLE.
- SETUP:
  - o_signal={op,a,b,dst,1'b0}, so the operands settle with no write.
  - flag_q<=mayor at the clock edge.
- WRITE: o_signal={op,a,b,dst,wr}; next state RESP.
- RESP:
  - o_signal=0, rsp_valid[owner]=1, rsp_flag=flag_q.
  - lock_q<=req_lock[owner]; next state IDLE.
- Handshake rules:
  - A transfer happens only when req_valid & req_ready.
  - Fields are sampled only in the accept cycle; requesters may change them afterwards.
  - A requester may drop valid before it is accepted; this has no side effect.
  - req_ready is 0 in every state except IDLE.
- Latency and throughput:
  - Accept cycle T → rsp_valid at T+3.
  - Back-to-back throughput is one operation per 4 cycles; the next accept can occur in the cycle after RESP.
- Lock:
  - If the owner asserts req_lock during RESP, it wins the next IDLE cycle in which it has valid set, bypassing round-robin.
  - The lock is cleared by any IDLE cycle in which the owner's valid is low.
  - Intended for compare-then-swap sequences.
- rsp_flag is meaningful only while any rsp_valid bit is set; it holds its value otherwise.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No rsp_valid is issued for the aborted operation, and that requester must resubmit.
- Outputs are glitch-free from registered state and cmd; the only combinational path is req_valid → req_ready in IDLE.
- rr_ptr wraps N_REQ-1 → 0.

Decomposition:
- Package dp_ctrl_pkg holds:
  - Control-word field widths and bit positions (ALU [15:13], A [12:9], B [8:5], DST [4:1], W [0]).
  - FSM state encodings.
  - A function that packs the control word from its fields.
- Sub-module rr_arbiter: purely combinational. Inputs are the req vector, rr_ptr, lock and owner; outputs are a one-hot grant and a binary index. It is reusable by other shared-resource blocks.

Test Plan:
- Single request: after reset, req_valid[2]=1 with op=3'b010, a=1, b=2, dst=3, wr=1.
  - req_ready[2] is asserted in the same cycle.
  - o_signal=16'h4246 (SETUP), then 16'h4247 (WRITE), then 0.
  - rsp_valid[2] is asserted 3 cycles after accept, and rsp_flag equals mayor sampled in SETUP.
- All four requesters hold valid continuously, no lock: grant order 0,1,2,3,0,1; accepts exactly 4 cycles apart; busy is high except in the accept cycles.
- Lock: requester 1 asserts req_lock and immediately re-requests while requester 2 is also waiting. Requester 1 wins twice in a row; once req_lock drops, requester 2 wins next.
- Flag capture: mayor=1 in SETUP and 0 in WRITE → rsp_flag=1. Repeat with mayor=0 in SETUP and 1 in WRITE → rsp_flag=0.
- Reset in the WRITE cycle: o_signal=0 and busy=0 immediately; no rsp_valid follows. The next request is granted starting from rr_ptr=0.
- Requester 3 drops valid while requester 0 is in progress: requester 3 never sees req_ready or rsp_valid, and the arbiter returns to IDLE and stays there.
